gs232c_bpred_redirect: RTL and testbench
========================================

// Module: gs232c_bpred_redirect
// PURPOSE
//  Fetch-side early-redirect stage placed directly downstream of instruction predecode.
//  - Takes each fetched word's PC plus its predecode flags and offset.
//  - Computes direct B/BL targets and predicts JIRL-return targets from a return address stack (RAS).
//  - Issues a one-cycle redirect to the fetch PC generator.
//  - Passes the instruction on to the decode queue through a one-entry valid/ready pipeline register.
// PARAMETERS
//  RAS_DEPTH  8  number of RAS entries (power of 2, >=2)
//  RAS_PW     3  log2(RAS_DEPTH), pointer width
// PORTS
//  clock          in   1   core clock
//  reset          in   1   asynchronous, active-high reset
//  flush          in   1   backend flush; kills the held entry and any redirect
//  ras_clear      in   1   empties the RAS (count=0, ptr=0)
//  in_valid       in   1   fetch word valid
//  in_ready       out  1   stage can accept this cycle
//  in_pc          in   32  PC of the word
//  in_inst        in   32  raw instruction, passed through
//  in_bl_b        in   1   predecode: B or BL (direct unconditional)
//  in_link        in   1   predecode: writes ra (BL, or JIRL with rd=ra)
//  in_jrra        in   1   predecode: JIRL r0,ra,0 (return)
//  in_offs        in   26  predecode: word offset, already sign-packed
//  out_valid      out  1   decode-queue entry valid
//  out_ready      in   1   decode queue accepts
//  out_pc         out  32  registered in_pc
//  out_inst       out  32  registered in_inst
//  out_taken      out  1   a redirect was predicted for this word
//  out_target     out  32  predicted target (0 when out_taken=0)
//  redirect_valid out  1   one-cycle pulse to fetch
//  redirect_pc    out  32  new fetch PC
// BEHAVIOUR
//  Reset
//  - All outputs 0. out_valid=0, redirect_valid=0.
//  - RAS count=0, ptr=0. RAS entry contents are don't-care.
//  Handshake
//  - in_ready = (!out_valid || out_ready) && !redirect_valid.
//  - accept = in_valid && in_ready && !flush.
//  - On accept, all out_* load on the next edge; out_valid=1.
//  - While out_valid && !out_ready, out_* hold unchanged.
//  - A completed transfer (out_valid && out_ready) with no accept in the same cycle clears out_valid.
//  Target arithmetic
//  - direct = in_pc + {{4{in_offs[25]}}, in_offs, 2'b00}, mod 2^32 (wraps silently).
//  - link address = in_pc + 4, mod 2^32.
//  Prediction (evaluated on accept only)
//  - in_bl_b: taken=1, target=direct.
//  - in_jrra with count>0: taken=1, target=RAS[ptr-1].
//  - in_jrra with count=0: taken=0; no RAS change.
//  - Otherwise: taken=0 (conditional branches and other JIRL are not predicted).
//  - in_jrra and in_link are mutually exclusive by encoding. If both are asserted: the pop is performed first, then the push.
//  RAS (circular)
//  - Push, on accept with in_link=1:
//    - RAS[ptr] <= pc+4; ptr <= ptr+1 (wraps mod RAS_DEPTH).
//    - count <= min(count+1, RAS_DEPTH).
//    - Push when full overwrites the oldest entry.
//  - Pop, on accept with in_jrra and count>0:
//    - ptr <= ptr-1 (wraps); count <= count-1.
//  - RAS updates only on accept. Stalls, flush and dropped words never modify it.
//  - ras_clear has priority over a same-cycle push or pop.
//  Redirect
//  - On accept with taken=1: next cycle redirect_valid=1 and redirect_pc=target, exactly one cycle.
//  - During that cycle in_ready=0; fetch supplies the corrected stream from the following cycle.
//  Flush
//  - On the next edge: out_valid=0, redirect_valid=0.
//  - A same-cycle in_valid is not accepted.
//  - flush asserted during a redirect cycle cancels nothing already issued, but no new accept occurs.
//  Reset mid-operation
//  - Returns every output and the RAS state to reset values immediately (async).
// TESTING
//  1. Reset, then B at pc=0x1c000000, offs=0x000010:
//     -> out_taken=1, out_target=0x1c000040, redirect_valid for one cycle with redirect_pc=0x1c000040.
//  2. Backward B at pc=0x1c000100, offs=0x3fffffc:
//     -> target 0x1c0000f0. Also pc=0xfffffffc with offs=1 -> target 0x00000000 (wrap).
//  3. BL at pc=0x1c000200, then JIRL r0,ra,0:
//     -> BL redirects; the return gets out_taken=1, out_target=0x1c000204; count returns to 0.
//  4. 9 BLs at pcs P0..P8 with RAS_DEPTH=8, then 9 returns:
//     -> targets P8+4 down to P1+4; the 9th return has out_taken=0.
//  5. out_ready=0 for 5 cycles with a BL held:
//     -> in_ready=0, out_* stable, RAS pushed exactly once.
//  6. flush asserted together with in_valid BL:
//     -> not accepted, no push, no redirect. A return on empty RAS -> out_taken=0, redirect_valid stays 0.

Source files
------------

// File: rtl/gs232c_bpred_redirect.sv
// Early-redirect stage after predecode: computes direct B/BL targets,
// predicts returns from a circular RAS, pulses a one-cycle redirect to fetch
// and hands the word to decode through a one-entry valid/ready register.
module gs232c_bpred_redirect #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned RAS_PW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        ras_clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        in_bl_b,
  input  logic        in_link,
  input  logic        in_jrra,
  input  logic [25:0] in_offs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_taken,
  output logic [31:0] out_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [RAS_PW-1:0] PTR_ONE  = RAS_PW'(1);
  localparam logic [RAS_PW:0]   CNT_ONE  = (RAS_PW+1)'(1);
  localparam logic [RAS_PW:0]   CNT_FULL = (RAS_PW+1)'(RAS_DEPTH);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_taken_q, out_taken_d;
  logic [31:0] out_target_q, out_target_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0]       ras_q [RAS_DEPTH];
  logic [31:0]       ras_d [RAS_DEPTH];
  logic [RAS_PW-1:0] ptr_q, ptr_d;
  logic [RAS_PW:0]   cnt_q, cnt_d;

  logic              accept;
  logic              taken;
  logic [31:0]       direct;
  logic [31:0]       link_addr;
  logic [31:0]       target;
  logic              pop;
  logic              push;
  logic [RAS_PW-1:0] ptr_mid;
  logic [RAS_PW:0]   cnt_mid;

  assign in_ready = (!out_valid_q || out_ready) && !redirect_valid_q;

  // Accept decision and target prediction for the incoming word
  always_comb begin
    accept    = in_valid && in_ready && !flush;
    direct    = in_pc + {{4{in_offs[25]}}, in_offs, 2'b00};
    link_addr = in_pc + 32'd4;
    taken     = 1'b0;
    target    = '0;
    if (in_bl_b) begin
      taken  = 1'b1;
      target = direct;
    end else if (in_jrra && (cnt_q != '0)) begin
      taken  = 1'b1;
      target = ras_q[ptr_q - PTR_ONE];
    end
  end

  // RAS next state: clear wins; otherwise pop first, then push on the popped pointer
  always_comb begin
    ras_d   = ras_q;
    pop     = accept && in_jrra && (cnt_q != '0);
    push    = accept && in_link;
    ptr_mid = pop ? (ptr_q - PTR_ONE) : ptr_q;
    cnt_mid = pop ? (cnt_q - CNT_ONE) : cnt_q;
    ptr_d   = ptr_mid;
    cnt_d   = cnt_mid;
    if (ras_clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      ras_d[ptr_mid] = link_addr;
      ptr_d          = ptr_mid + PTR_ONE;
      if (cnt_mid != CNT_FULL) cnt_d = cnt_mid + CNT_ONE;
    end
  end

  // Output register and redirect pulse next state
  always_comb begin
    out_valid_d      = out_valid_q;
    out_pc_d         = out_pc_q;
    out_inst_d       = out_inst_q;
    out_taken_d      = out_taken_q;
    out_target_d     = out_target_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = accept && taken;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_inst_d   = in_inst;
      out_taken_d  = taken;
      out_target_d = target;
      if (taken) redirect_pc_d = target;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_valid_d      = 1'b0;
      redirect_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_inst_q       <= '0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ptr_q            <= '0;
      cnt_q            <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_pc_q         <= out_pc_d;
      out_inst_q       <= out_inst_d;
      out_taken_q      <= out_taken_d;
      out_target_q     <= out_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      ptr_q            <= ptr_d;
      cnt_q            <= cnt_d;
      ras_q            <= ras_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_taken      = out_taken_q;
  assign out_target     = out_target_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_gs232c_bpred_redirect.sv
// Scoreboard bench for gs232c_bpred_redirect: a reference model with a
// bounded return stack predicts every delivered word and redirect pulse.
module tb_gs232c_bpred_redirect;

  localparam int RAS_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush, ras_clear, in_valid, in_bl_b, in_link, in_jrra, out_ready;
  logic [31:0] in_pc, in_inst;
  logic [25:0] in_offs;
  logic        in_ready, out_valid, out_taken, redirect_valid;
  logic [31:0] out_pc, out_inst, out_target, redirect_pc;

  gs232c_bpred_redirect #(.RAS_DEPTH(8), .RAS_PW(3)) dut (
    .clock(clock), .reset(reset), .flush(flush), .ras_clear(ras_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_bl_b(in_bl_b), .in_link(in_link), .in_jrra(in_jrra), .in_offs(in_offs),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_taken(out_taken), .out_target(out_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] tg;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ras_m[$];
  logic        mvalid, mredir, last_acc;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] dtarget(logic [31:0] pc, logic [25:0] offs);
    logic signed [31:0] words;
    words = {{6{offs[25]}}, offs};
    return pc + 32'(words * 4);
  endfunction

  // Monitor: consumes delivered words and redirect pulses against the scoreboard
  initial begin
    exp_t e;
    logic [31:0] r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
          else begin
            e = sb_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_inst", out_inst, e.inst);
            chk("out_taken", {31'd0, out_taken}, {31'd0, e.tk});
            chk("out_target", out_target, e.tg);
          end
        end
        if (redirect_valid) begin
          if (rd_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
          else begin
            r = rd_q.pop_front();
            chk("redirect_pc", redirect_pc, r);
          end
        end
      end
    end
  end

  // One clock of the reference model; inputs are already driven by the caller
  task automatic cycle();
    logic        rdy, acc, tk;
    logic [31:0] tg;
    @(negedge clock); #1;
    rdy = (!mvalid || out_ready) && !mredir;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mredir});
    acc = in_valid && rdy && !flush;
    tk  = 1'b0;
    tg  = '0;
    if (acc) begin
      if (in_bl_b) begin
        tk = 1'b1;
        tg = dtarget(in_pc, in_offs);
      end else if (in_jrra && ras_m.size() > 0) begin
        tk = 1'b1;
        tg = ras_m[$];
      end
      sb_q.push_back('{in_pc, in_inst, tk, tg});
      if (tk) rd_q.push_back(tg);
    end
    if (flush && mvalid && !out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
    if (ras_clear) ras_m.delete();
    else if (acc) begin
      if (in_jrra && ras_m.size() > 0) void'(ras_m.pop_back());
      if (in_link) begin
        ras_m.push_back(in_pc + 32'd4);
        if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
      end
    end
    if (flush) mvalid = 1'b0;
    else if (acc) mvalid = 1'b1;
    else if (mvalid && out_ready) mvalid = 1'b0;
    mredir   = acc && tk;
    last_acc = acc;
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_bl_b = 0; in_link = 0; in_jrra = 0;
    flush = 0; ras_clear = 0; in_offs = '0; in_pc = '0; in_inst = '0;
  endtask

  // Present one word and hold it until the model says it was accepted
  task automatic send(input logic [31:0] pc, input logic bl, input logic link,
                      input logic jrra, input logic [25:0] offs);
    bit done;
    done     = 0;
    in_valid = 1; in_pc = pc; in_inst = $urandom; in_offs = offs;
    in_bl_b  = bl; in_link = link; in_jrra = jrra;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    idle_inputs();
  endtask

  task automatic reset_model();
    sb_q.delete(); rd_q.delete(); ras_m.delete();
    mvalid = 0; mredir = 0; last_acc = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_target", out_target, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
  endtask

  initial begin
    int t;
    reset = 1; out_ready = 1;
    idle_inputs();
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 0;

    // Forward B, backward B, wrapping B
    send(32'h1c000000, 1, 0, 0, 26'h0000010);
    repeat (2) cycle();
    send(32'h1c000100, 1, 0, 0, 26'h3fffffc);
    send(32'hfffffffc, 1, 0, 0, 26'h0000001);
    repeat (2) cycle();

    // BL then return
    send(32'h1c000200, 1, 1, 0, 26'h0000040);
    send(32'h1c000300, 0, 0, 1, 26'h0);
    repeat (2) cycle();

    // Nine calls overflow the 8-deep stack, then nine returns
    for (int i = 0; i < 9; i++) send(32'h1c001000 + 32'(i * 256), 1, 1, 0, 26'h10);
    for (int i = 0; i < 9; i++) send(32'h1c008000 + 32'(i * 16), 0, 0, 1, 26'h0);
    repeat (2) cycle();

    // Held BL under backpressure while another word waits
    out_ready = 0;
    send(32'h1c002000, 1, 1, 0, 26'h20);
    in_valid = 1; in_pc = 32'h1c003000; in_inst = $urandom; in_link = 1; in_bl_b = 1;
    repeat (5) cycle();
    out_ready = 1;
    idle_inputs();
    repeat (2) cycle();
    send(32'h1c004000, 0, 0, 1, 26'h0);
    repeat (2) cycle();

    // Flush with a same-cycle BL, then a return on an empty stack
    ras_clear = 1; cycle(); ras_clear = 0;
    in_valid = 1; in_pc = 32'h1c005000; in_inst = $urandom; in_bl_b = 1; in_link = 1;
    in_offs = 26'h8; flush = 1;
    cycle();
    idle_inputs();
    send(32'h1c006000, 0, 0, 1, 26'h0);
    repeat (2) cycle();

    // Flush killing a held entry
    out_ready = 0;
    send(32'h1c007000, 0, 0, 0, 26'h0);
    flush = 1; cycle(); flush = 0;
    out_ready = 1;
    repeat (2) cycle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      t         = $urandom_range(0, 5);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = {$urandom_range(0, 7) == 0 ? 30'h3fffffff - 30'($urandom_range(0, 3)) : 30'($urandom), 2'b00};
      in_inst   = $urandom;
      in_offs   = 26'($urandom);
      in_bl_b   = (t == 1) || (t == 2);
      in_link   = (t == 2) || (t == 3) || (t == 5);
      in_jrra   = (t == 4) || (t == 5);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      ras_clear = ($urandom_range(0, 39) == 0);
      cycle();
      if (n == 1200) begin
        // Asynchronous reset mid-traffic
        reset = 1; #1;
        check_reset_outputs();
        reset_model();
        @(posedge clock); #1;
        reset = 0;
      end
    end

    // Drain and confirm nothing is left outstanding
    idle_inputs();
    out_ready = 1;
    repeat (4) cycle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("redirect_drained", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
